// File: rtl/wave_meter.sv
// wave_meter: measures the period between successive waveform events and the min/max
// amplitude inside each period. One result per period is offered on a valid/ready handshake.
//   clk        clock
//   rst_n      asynchronous active-low reset
//   enable_i   0: clear measurement state and idle, 1: measure
//   mode_i     0: peak (extremum) detect, 1: rising zero-cross detect
//   wave_i     signed input sample
//   clear_i    clears the sticky overrun_o / timeout_o flags
//   res_valid  result available
//   res_ready  consumer accepts the result when res_valid & res_ready at posedge
//   period_o   clk cycles between the last two events
//   max_o      signed maximum sample in that period, both event samples included
//   min_o      signed minimum sample in that period, both event samples included
//   overrun_o  sticky: an event occurred while a result was still pending
//   timeout_o  sticky: the period counter saturated
module wave_meter #(
    parameter int DATA_WIDTH = 16,
    parameter int PER_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable_i,
    input  logic                         mode_i,
    input  logic signed [DATA_WIDTH-1:0] wave_i,
    input  logic                         clear_i,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic        [PER_WIDTH-1:0]  period_o,
    output logic signed [DATA_WIDTH-1:0] max_o,
    output logic signed [DATA_WIDTH-1:0] min_o,
    output logic                         overrun_o,
    output logic                         timeout_o
);
    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_MEASURE} state_t;

    localparam logic [PER_WIDTH-1:0] CNT_MAX = '1;

    state_t                         state, state_nx;
    logic signed [DATA_WIDTH-1:0]   prev, run_max, run_min, run_max_nx, run_min_nx;
    logic signed [DATA_WIDTH-1:0]   cand_max, cand_min;
    logic        [PER_WIDTH-1:0]    cnt, cnt_nx, cnt_inc;
    logic                           trend_up, trend_up_nx, mode_q;
    logic                           mode_chg, evt, cand, sat, load, ovr_set;

    // prev <= 0 and wave_i > 0, written on sign bits to keep the compare signed
    assign evt      = mode_i ? ((prev[DATA_WIDTH-1] || prev == '0) && !wave_i[DATA_WIDTH-1] && wave_i != '0)
                             : (trend_up && wave_i < prev);
    assign mode_chg = mode_i != mode_q;
    assign cand_max = wave_i > run_max ? wave_i : run_max;
    assign cand_min = wave_i < run_min ? wave_i : run_min;
    // the counter never sits at CNT_MAX while measuring, so this cannot wrap
    assign cnt_inc  = cnt + 1'b1;
    assign load     = cand && (!res_valid || res_ready);
    assign ovr_set  = cand && !load;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        run_max_nx  = run_max;
        run_min_nx  = run_min;
        trend_up_nx = wave_i > prev ? 1'b1 : wave_i < prev ? 1'b0 : trend_up;
        cand        = 1'b0;
        sat         = 1'b0;
        if (!enable_i) begin
            state_nx    = S_IDLE;
            cnt_nx      = '0;
            run_max_nx  = '0;
            run_min_nx  = '0;
            trend_up_nx = 1'b0;
        end else if (mode_chg) begin
            state_nx    = S_ACQUIRE;
            trend_up_nx = 1'b0;
        end else begin
            case (state)
                S_IDLE: state_nx = S_ACQUIRE;
                S_ACQUIRE: begin
                    if (evt) begin
                        state_nx   = S_MEASURE;
                        cnt_nx     = {{(PER_WIDTH-1){1'b0}}, 1'b1};
                        run_max_nx = wave_i;
                        run_min_nx = wave_i;
                    end
                end
                S_MEASURE: begin
                    if (evt) begin
                        cand       = 1'b1;
                        cnt_nx     = {{(PER_WIDTH-1){1'b0}}, 1'b1};
                        run_max_nx = wave_i;
                        run_min_nx = wave_i;
                    end else begin
                        cnt_nx     = cnt_inc;
                        run_max_nx = cand_max;
                        run_min_nx = cand_min;
                        // a saturated period is meaningless: flag it and re-arm
                        if (cnt_inc == CNT_MAX) begin
                            sat      = 1'b1;
                            state_nx = S_ACQUIRE;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prev      <= '0;
            trend_up  <= 1'b0;
            mode_q    <= 1'b0;
            cnt       <= '0;
            run_max   <= '0;
            run_min   <= '0;
            res_valid <= 1'b0;
            period_o  <= '0;
            max_o     <= '0;
            min_o     <= '0;
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nx;
            prev      <= wave_i;
            trend_up  <= trend_up_nx;
            mode_q    <= mode_i;
            cnt       <= cnt_nx;
            run_max   <= run_max_nx;
            run_min   <= run_min_nx;
            if (!enable_i) begin
                res_valid <= 1'b0;
            end else if (load) begin
                res_valid <= 1'b1;
                period_o  <= cnt;
                max_o     <= cand_max;
                min_o     <= cand_min;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            overrun_o <= ovr_set | (overrun_o & ~clear_i);
            timeout_o <= sat | (timeout_o & ~clear_i);
        end
    end
endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: table vectors, directed corner sequences and random stimulus for wave_meter
module tb_wave_meter;
    localparam int DW   = 8;
    localparam int PW   = 6;
    localparam int CMAX = (1 << PW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 mode = 1'b0;
    logic                 clear = 1'b0;
    logic                 res_ready = 1'b0;
    logic signed [DW-1:0] wave = '0;
    logic                 res_valid, overrun, timeout;
    logic        [PW-1:0] period;
    logic signed [DW-1:0] max_v, min_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wave_meter #(.DATA_WIDTH(DW), .PER_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .mode_i(mode), .wave_i(wave),
        .clear_i(clear), .res_valid(res_valid), .res_ready(res_ready), .period_o(period),
        .max_o(max_v), .min_o(min_v), .overrun_o(overrun), .timeout_o(timeout)
    );

    // reference model: keeps the samples since the last event and evaluates the rules directly
    bit m_valid, m_ovr, m_to, m_up, m_mode, m_active, m_armed;
    int m_period, m_max, m_min, m_prev;
    int hist[$];

    task automatic model_reset();
        m_valid = 0; m_ovr = 0; m_to = 0; m_up = 0; m_mode = 0; m_active = 0; m_armed = 0;
        m_period = 0; m_max = 0; m_min = 0; m_prev = 0;
        hist.delete();
    endtask

    task automatic model_step();
        int w, c_per, c_max, c_min;
        bit evt, cand, sat, ovr_set;
        w = wave; cand = 0; sat = 0; ovr_set = 0; c_per = 0; c_max = 0; c_min = 0;
        if (!enable) begin
            m_active = 0; m_armed = 0; m_up = 0; hist.delete();
        end else if (mode != m_mode || !m_active) begin
            m_up = (mode != m_mode) ? 1'b0 : (w > m_prev ? 1'b1 : (w < m_prev ? 1'b0 : m_up));
            m_active = 1; m_armed = 0;
        end else begin
            evt = mode ? (m_prev <= 0 && w > 0) : (m_up && w < m_prev);
            if (m_armed && evt) begin
                cand = 1; c_per = hist.size(); c_max = w; c_min = w;
                foreach (hist[i]) begin
                    if (hist[i] > c_max) c_max = hist[i];
                    if (hist[i] < c_min) c_min = hist[i];
                end
                hist.delete(); hist.push_back(w);
            end else if (m_armed) begin
                hist.push_back(w);
                if (hist.size() == CMAX) begin sat = 1; m_armed = 0; end
            end else if (evt) begin
                m_armed = 1; hist.delete(); hist.push_back(w);
            end
            m_up = w > m_prev ? 1'b1 : (w < m_prev ? 1'b0 : m_up);
        end
        m_prev = w; m_mode = mode;
        if (!enable) m_valid = 0;
        else if (cand && (!m_valid || res_ready)) begin
            m_valid = 1; m_period = c_per; m_max = c_max; m_min = c_min;
        end else begin
            if (cand) ovr_set = 1;
            if (m_valid && res_ready) m_valid = 0;
        end
        m_ovr = ovr_set || (m_ovr && !clear);
        m_to  = sat || (m_to && !clear);
    endtask

    task automatic compare(input string name);
        checks++;
        if (res_valid !== m_valid || period !== PW'(m_period) || max_v !== DW'(m_max) ||
            min_v !== DW'(m_min) || overrun !== m_ovr || timeout !== m_to) begin
            errors++;
            $display("FAIL %s t=%0t got v=%b p=%0d max=%0d min=%0d ovr=%b to=%b want v=%b p=%0d max=%0d min=%0d ovr=%b to=%b",
                     name, $time, res_valid, period, max_v, min_v, overrun, timeout,
                     m_valid, m_period, m_max, m_min, m_ovr, m_to);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
        end
    endtask

    task automatic cyc(input string name);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare(name);
    endtask

    function automatic int sample(input int shape, input int k, input int a);
        int p;
        case (shape)
            0: begin p = k % (4 * a); return p <= 2 * a ? p - a : 3 * a - p; end
            1: return (k % 16) < 5 ? 64 : -64;
            2: return (k % 16) - 8;
            3: return int'($urandom_range(200)) - 100;
            default: return a;
        endcase
    endfunction

    task automatic restart(input bit md, input bit rdy);
        enable = 0; res_ready = rdy; clear = 0; cyc("idle");
        enable = 1; mode = md; cyc("arm");
    endtask

    typedef struct { int shape; bit md; int n; int per; int mx; int mn; } vec_t;
    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nres, k, first, hp, hx, hn, nv;
        bit hit;
        vecs[0] = '{0, 1'b0, 60, 12, 3, -3};
        vecs[1] = '{1, 1'b1, 64, 16, 64, -64};
        vecs[2] = '{2, 1'b0, 64, 16, 7, -8};
        vecs[3] = '{1, 1'b0, 64, 16, 64, -64};
        model_reset();
        repeat (2) @(negedge clk);
        compare("reset");
        rst_n = 1;

        foreach (vecs[v]) begin
            restart(vecs[v].md, 1'b1);
            nres = 0;
            for (int i = 0; i < vecs[v].n; i++) begin
                wave = DW'(sample(vecs[v].shape, i, 3));
                cyc("table");
                if (res_valid) begin
                    nres++;
                    expect_int("table period", int'(period), vecs[v].per);
                    expect_int("table max", int'(max_v), vecs[v].mx);
                    expect_int("table min", int'(min_v), vecs[v].mn);
                end
            end
            checks++;
            if (nres < 2) begin errors++; $display("FAIL table results got %0d want >=2", nres); end
        end

        // halt after a saw: no results, timeout once the counter saturates
        clear = 1; cyc("pre clear"); clear = 0;
        restart(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin wave = DW'(sample(2, i, 0)); cyc("saw"); end
        nv = 0; hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cyc("halt");
            if (i > 1 && res_valid) nv++;
            hit = timeout;
        end
        expect_int("halt timeout", int'(hit), 1);
        expect_int("halt results", nv, 0);
        clear = 1; cyc("clear"); clear = 0;
        expect_int("timeout cleared", int'(timeout), 0);

        // consumer stalls: first result held, later events overrun
        restart(1'b0, 1'b0);
        k = 0;
        while (!res_valid && k < 60) begin wave = DW'(sample(0, k, 3)); cyc("stall wait"); k++; end
        expect_int("stall result seen", int'(res_valid), 1);
        hp = int'(period); hx = int'(max_v); hn = int'(min_v);
        for (int i = 0; i < 30; i++) begin
            wave = DW'(sample(0, k, 3)); k++; cyc("stall");
            checks++;
            if (!res_valid || int'(period) != hp || int'(max_v) != hx || int'(min_v) != hn) begin
                errors++;
                $display("FAIL stall hold got v=%b p=%0d want p=%0d", res_valid, period, hp);
            end
        end
        expect_int("stall overrun", int'(overrun), 1);
        expect_int("accepted period", int'(period), 12);
        res_ready = 1; wave = DW'(sample(0, k, 3)); k++; cyc("accept");
        clear = 1; wave = DW'(sample(0, k, 3)); k++; cyc("ovr clear"); clear = 0;
        expect_int("overrun cleared", int'(overrun), 0);

        // asynchronous reset in the middle of a measurement
        restart(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin wave = DW'(sample(0, i, 3)); cyc("pre rst"); end
        #2 rst_n = 0;
        #1;
        checks++;
        if (res_valid !== 0 || period !== 0 || max_v !== 0 || min_v !== 0 || overrun !== 0 || timeout !== 0) begin
            errors++;
            $display("FAIL async reset got v=%b p=%0d max=%0d min=%0d want all 0", res_valid, period, max_v, min_v);
        end
        model_reset();
        @(negedge clk);
        compare("in reset");
        rst_n = 1;
        first = -1;
        for (int i = 0; i < 60 && first < 0; i++) begin
            wave = DW'(sample(0, i, 3));
            cyc("post rst");
            if (res_valid) begin first = i; expect_int("post rst period", int'(period), 12); end
        end
        expect_int("post rst first result cycle", first, 19);

        // random segments of mixed shapes, modes, stalls, clears and enable drops
        for (int s = 0; s < 30; s++) begin
            int shape, len, amp;
            shape = int'($urandom_range(4));
            len   = 20 + int'($urandom_range(100));
            amp   = 2 + int'($urandom_range(20));
            mode  = $urandom_range(1);
            for (int i = 0; i < len; i++) begin
                wave      = DW'(sample(shape, i, amp));
                res_ready = $urandom_range(9) < 7;
                clear     = $urandom_range(19) == 0;
                enable    = $urandom_range(49) != 0;
                cyc("random");
            end
        end
        clear = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
